scan_seq_ctl: RTL and testbench
===============================

SCAN_SEQ_CTL -- requirements
Module: scan_seq_ctl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 839, giving the shift cycles per load/unload (836 core cells + 3 I/O cells).
REQ-002 SHALL have parameter CAP_PULSES, default 1, giving capture-clock enable cycles per pattern (legal 1..4).
REQ-003 SHALL have parameter ENTRY_CYC, default 16, giving the consecutive tst_i-high cycles required to enter test mode.
REQ-004 SHALL have port clk, input, 1 bit: single block clock.
REQ-005 SHALL have port srstz, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port tst_i, input, 1 bit: TST pin level, already synchronized to clk.
REQ-007 SHALL have port start_i, input, 1 bit: one-cycle request to run one load/capture/unload pattern.
REQ-008 SHALL have port test_mode_o, output, 1 bit: test mode active.
REQ-009 SHALL have port scan_en_o, output, 1 bit: scan-enable to all chain muxes.
REQ-010 SHALL have port cap_en_o, output, 1 bit: capture-clock gate enable.
REQ-011 SHALL have port shift_cnt_o, output, 10 bits: current shift index.
REQ-012 SHALL have port busy_o, output, 1 bit: a pattern is in progress.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle pulse at the end of a pattern.
REQ-014 SHALL have port pat_cnt_o, output, 16 bits: patterns completed since test-mode entry.

Function
REQ-015 SHALL implement the states OFF, ARM, IDLE, SHIFT, SETTLE, CAPTURE and UNLOAD.
REQ-016 OFF SHALL go to ARM when tst_i=1.
REQ-017 ARM SHALL count consecutive tst_i=1 cycles, go to IDLE when the count reaches ENTRY_CYC, and return to OFF with the count cleared when tst_i=0.
REQ-018 test_mode_o SHALL be 1 in IDLE, SHIFT, SETTLE, CAPTURE and UNLOAD, and 0 otherwise.
REQ-019 In IDLE, start_i=1 SHALL go to SHIFT on the next cycle; start_i SHALL be ignored in every other state.
REQ-020 SHIFT SHALL assert scan_en_o for exactly CHAIN_LEN cycles, with shift_cnt_o going 0..CHAIN_LEN-1, then go to SETTLE.
REQ-021 SETTLE SHALL last exactly 1 cycle with scan_en_o=0 and cap_en_o=0 (scan-enable settling), then go to CAPTURE.
REQ-022 CAPTURE SHALL assert cap_en_o for exactly CAP_PULSES cycles with scan_en_o=0, then go to UNLOAD.
REQ-023 UNLOAD SHALL assert scan_en_o for CHAIN_LEN cycles, with shift_cnt_o going 0..CHAIN_LEN-1.
REQ-024 On the last UNLOAD cycle the block SHALL pulse done_o for 1 cycle, increment pat_cnt_o, and go to IDLE.
REQ-025 pat_cnt_o SHALL saturate at 16'hFFFF and SHALL clear on entry to ARM.
REQ-026 busy_o SHALL be 1 in SHIFT, SETTLE, CAPTURE and UNLOAD.
REQ-027 scan_en_o and cap_en_o SHALL never both be 1, and each SHALL be glitch-free registered outputs.
REQ-028 From any test-mode state, tst_i=0 SHALL go to OFF on the next cycle, clear the counters, deassert all outputs, and not pulse done_o.
REQ-029 shift_cnt_o SHALL hold 0 outside SHIFT and UNLOAD.
REQ-030 Latency from start_i to done_o SHALL be exactly 2*CHAIN_LEN + CAP_PULSES + 1 cycles.

Reset
REQ-031 srstz=0 SHALL asynchronously force state OFF, all counters to 0, and all outputs to 0.
REQ-032 Release of srstz SHALL take effect on the next clk edge; a reset in mid-pattern SHALL abort the pattern without a done_o pulse.

Structure
REQ-033 State encoding and the CHAIN_LEN, CAP_PULSES and ENTRY_CYC defaults SHALL live in a shared package scan_pkg.
REQ-034 The ENTRY_CYC debounce counter SHALL be the sub-module tst_entry_dbnc; everything else SHALL be flat.

Verification
REQ-035 Entry glitch: tst_i high for 15 cycles, low, then high for 16 -> test_mode_o stays 0 after the first burst and goes 1 on the 16th cycle of the second burst.
REQ-036 Single pattern at defaults: start_i pulse -> scan_en_o high 839 cycles, 1 cycle both low, cap_en_o high 1 cycle, scan_en_o high 839 cycles, done_o at cycle 1680, pat_cnt_o=1.
REQ-037 start_i pulsed during SHIFT -> ignored, only one done_o pulse, pat_cnt_o increments by 1.
REQ-038 With CAP_PULSES=3 -> exactly 3 cap_en_o cycles, and start-to-done latency of 1682 cycles.
REQ-039 tst_i drops at shift_cnt_o=400 of UNLOAD -> all outputs 0 next cycle, no done_o, and re-entry clears pat_cnt_o.
REQ-040 srstz asserted mid-CAPTURE -> immediate state OFF with all outputs 0; an assertion checks scan_en_o & cap_en_o is never 1 throughout.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared state encoding, default geometry and helpers for the scan sequencer.
package scan_pkg;

  localparam int unsigned DEF_CHAIN_LEN  = 839;
  localparam int unsigned DEF_CAP_PULSES = 1;
  localparam int unsigned DEF_ENTRY_CYC  = 16;

  localparam int SHIFT_W = 10;
  localparam int PAT_W   = 16;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ARM,
    ST_IDLE,
    ST_SHIFT,
    ST_SETTLE,
    ST_CAPTURE,
    ST_UNLOAD
  } scan_state_e;

  // Pattern counter stops at all-ones instead of wrapping.
  function automatic logic [PAT_W-1:0] satInc(input logic [PAT_W-1:0] v);
    return (v == '1) ? v : v + PAT_W'(1);
  endfunction

endpackage

// File: rtl/tst_entry_dbnc.sv
// Counts consecutive TST-high cycles while the sequencer is outside test mode.
module tst_entry_dbnc
  import scan_pkg::*;
#(
  parameter int unsigned ENTRY_CYC = DEF_ENTRY_CYC
) (
  input  logic clk,
  input  logic srstz,
  input  logic en_i,
  input  logic tst_i,
  output logic reached_o
);

  localparam int CNT_W = (ENTRY_CYC > 1) ? $clog2(ENTRY_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENTRY_CYC - 1);

  logic [CNT_W-1:0] runCnt_q;
  logic [CNT_W-1:0] runCnt_d;

  // Any low sample, or leaving the entry states, restarts the run from zero.
  always_comb begin
    runCnt_d = '0;
    if (en_i && tst_i && (runCnt_q != CNT_LAST)) begin
      runCnt_d = runCnt_q + CNT_W'(1);
    end
  end

  assign reached_o = en_i && tst_i && (runCnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge srstz) begin
    if (!srstz) begin
      runCnt_q <= '0;
    end else begin
      runCnt_q <= runCnt_d;
    end
  end

endmodule

// File: rtl/scan_seq_ctl.sv
// Scan test sequencer: TST-pin entry, then load / settle / capture / unload per start request.
module scan_seq_ctl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int unsigned CAP_PULSES = DEF_CAP_PULSES,
  parameter int unsigned ENTRY_CYC  = DEF_ENTRY_CYC
) (
  input  logic               clk,
  input  logic               srstz,
  input  logic               tst_i,
  input  logic               start_i,
  output logic               test_mode_o,
  output logic               scan_en_o,
  output logic               cap_en_o,
  output logic [SHIFT_W-1:0] shift_cnt_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [PAT_W-1:0]   pat_cnt_o
);

  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CHAIN_LEN - 1);
  localparam logic [1:0]         CAP_LAST   = 2'(CAP_PULSES - 1);

  scan_state_e        state_q, state_d;
  logic [SHIFT_W-1:0] shiftCnt_q, shiftCnt_d;
  logic [1:0]         capCnt_q, capCnt_d;
  logic [PAT_W-1:0]   patCnt_q, patCnt_d;
  logic               testMode_q, scanEn_q, capEn_q, busy_q, done_q;
  logic               entryReached;

  tst_entry_dbnc #(
    .ENTRY_CYC(ENTRY_CYC)
  ) u_dbnc (
    .clk      (clk),
    .srstz    (srstz),
    .en_i     ((state_q == ST_OFF) || (state_q == ST_ARM)),
    .tst_i    (tst_i),
    .reached_o(entryReached)
  );

  always_comb begin
    state_d    = state_q;
    shiftCnt_d = '0;
    capCnt_d   = '0;
    patCnt_d   = patCnt_q;
    case (state_q)
      ST_OFF: begin
        patCnt_d = '0;
        if (tst_i) state_d = entryReached ? ST_IDLE : ST_ARM;
      end
      ST_ARM: begin
        if (!tst_i)            state_d = ST_OFF;
        else if (entryReached) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (start_i) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shiftCnt_q == SHIFT_LAST) state_d = ST_SETTLE;
        else                          shiftCnt_d = shiftCnt_q + SHIFT_W'(1);
      end
      ST_SETTLE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (capCnt_q == CAP_LAST) state_d = ST_UNLOAD;
        else                      capCnt_d = capCnt_q + 2'd1;
      end
      ST_UNLOAD: begin
        if (shiftCnt_q == SHIFT_LAST) begin
          state_d  = ST_IDLE;
          patCnt_d = satInc(patCnt_q);
        end else begin
          shiftCnt_d = shiftCnt_q + SHIFT_W'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
    // Losing TST aborts whatever is running, including a pattern on its last cycle.
    if ((state_q != ST_OFF) && !tst_i) begin
      state_d    = ST_OFF;
      shiftCnt_d = '0;
      capCnt_d   = '0;
      patCnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they leave a flop, never a gate.
  always_ff @(posedge clk or negedge srstz) begin
    if (!srstz) begin
      state_q    <= ST_OFF;
      shiftCnt_q <= '0;
      capCnt_q   <= '0;
      patCnt_q   <= '0;
      testMode_q <= 1'b0;
      scanEn_q   <= 1'b0;
      capEn_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftCnt_q <= shiftCnt_d;
      capCnt_q   <= capCnt_d;
      patCnt_q   <= patCnt_d;
      testMode_q <= state_d inside {ST_IDLE, ST_SHIFT, ST_SETTLE, ST_CAPTURE, ST_UNLOAD};
      busy_q     <= state_d inside {ST_SHIFT, ST_SETTLE, ST_CAPTURE, ST_UNLOAD};
      scanEn_q   <= state_d inside {ST_SHIFT, ST_UNLOAD};
      capEn_q    <= (state_d == ST_CAPTURE);
      done_q     <= (state_d == ST_UNLOAD) && (shiftCnt_d == SHIFT_LAST);
    end
  end

  assign test_mode_o = testMode_q;
  assign scan_en_o   = scanEn_q;
  assign cap_en_o    = capEn_q;
  assign shift_cnt_o = shiftCnt_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pat_cnt_o   = patCnt_q;

endmodule

// File: tb/tb_scan_seq_ctl.sv
// Drives two sequencers (1 and 3 capture pulses) with shared stimulus and
// checks them against a timeline model plus a done_o scoreboard.
module tb_scan_seq_ctl;

  localparam int CL    = 839;
  localparam int ENTRY = 16;
  localparam int CPV [2] = '{1, 3};

  logic       clk = 1'b0;
  logic       srstz = 1'b0;
  logic       tstI = 1'b0;
  logic       startI = 1'b0;
  logic [1:0] tmO, scanO, capO, busyO, doneO;
  logic [9:0] shiftO [2];
  logic [15:0] patO [2];

  int compared = 0;
  int mismatched = 0;

  int pe = 0;
  int runHigh = 0;
  bit active [2] = '{0, 0};
  int startEdge [2] = '{0, 0};
  int patM [2] = '{0, 0};
  int doneQ [2][$];
  bit doneSeen [2] = '{0, 0};

  always #5 clk = ~clk;

  scan_seq_ctl #(.CHAIN_LEN(CL), .CAP_PULSES(1), .ENTRY_CYC(ENTRY)) dut0 (
    .clk(clk), .srstz(srstz), .tst_i(tstI), .start_i(startI),
    .test_mode_o(tmO[0]), .scan_en_o(scanO[0]), .cap_en_o(capO[0]),
    .shift_cnt_o(shiftO[0]), .busy_o(busyO[0]), .done_o(doneO[0]),
    .pat_cnt_o(patO[0])
  );

  scan_seq_ctl #(.CHAIN_LEN(CL), .CAP_PULSES(3), .ENTRY_CYC(ENTRY)) dut1 (
    .clk(clk), .srstz(srstz), .tst_i(tstI), .start_i(startI),
    .test_mode_o(tmO[1]), .scan_en_o(scanO[1]), .cap_en_o(capO[1]),
    .shift_cnt_o(shiftO[1]), .busy_o(busyO[1]), .done_o(doneO[1]),
    .pat_cnt_o(patO[1])
  );

  function automatic int lat(int i);
    return 2 * CL + CPV[i] + 1;
  endfunction

  function automatic int packOuts(int i);
    return int'({tmO[i], scanO[i], capO[i], busyO[i], doneO[i], shiftO[i], patO[i]});
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0d required %0d (edge %0d)", name, act, exp, pe);
    end
  endtask

  task automatic clearModel();
    runHigh = 0;
    for (int i = 0; i < 2; i++) begin
      active[i] = 0;
      patM[i] = 0;
      doneQ[i].delete();
    end
  endtask

  // Reference model: advances once per edge from the sampled inputs.
  initial begin
    bit idleBefore;
    forever begin
      @(posedge clk or negedge srstz);
      if (!srstz) begin
        clearModel();
      end else begin
        pe++;
        if (!tstI) begin
          clearModel();
        end else begin
          for (int i = 0; i < 2; i++) begin
            idleBefore = (runHigh >= ENTRY) && !active[i];
            if (active[i] && (pe == startEdge[i] + lat(i))) begin
              patM[i] = (patM[i] == 65535) ? patM[i] : patM[i] + 1;
              active[i] = 0;
              checkOutput($sformatf("pendingDone%0d", i), doneQ[i].size(), 0);
              doneQ[i].delete();
            end
            if (idleBefore && startI) begin
              active[i] = 1;
              startEdge[i] = pe;
              doneQ[i].push_back(pe + lat(i) - 1);
            end
          end
          if (runHigh < ENTRY) runHigh++;
        end
      end
    end
  end

  // Monitor: compares every output once per cycle and pops the scoreboard on done_o.
  initial begin
    int t, expShift, expDone;
    bit expScan, expCap;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        t = pe - startEdge[i];
        expScan  = active[i] && ((t < CL) || (t >= CL + CPV[i] + 1));
        expCap   = active[i] && (t >= CL + 1) && (t <= CL + CPV[i]);
        expShift = !active[i] ? 0 : (t < CL) ? t : (t >= CL + CPV[i] + 1) ? t - CL - CPV[i] - 1 : 0;
        checkOutput($sformatf("testMode%0d", i), int'(tmO[i]), int'(runHigh >= ENTRY));
        checkOutput($sformatf("busy%0d", i), int'(busyO[i]), int'(active[i]));
        checkOutput($sformatf("scanEn%0d", i), int'(scanO[i]), int'(expScan));
        checkOutput($sformatf("capEn%0d", i), int'(capO[i]), int'(expCap));
        checkOutput($sformatf("shiftCnt%0d", i), int'(shiftO[i]), expShift);
        checkOutput($sformatf("patCnt%0d", i), int'(patO[i]), patM[i]);
        assert (!(scanO[i] && capO[i]))
          else $error("[TB] scan_en and cap_en both high on instance %0d", i);
        if (doneO[i]) begin
          doneSeen[i] = 1;
          if (doneQ[i].size() != 0) begin
            expDone = doneQ[i].pop_front();
            checkOutput($sformatf("doneEdge%0d", i), pe, expDone);
          end else begin
            checkOutput($sformatf("spuriousDone%0d", i), int'(doneO[i]), 0);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input bit tst, input bit start);
    tstI = tst;
    startI = start;
    @(negedge clk);
  endtask

  task automatic runPattern(input int extraAt);
    applyStimulus(1, 0);
    doneSeen = '{0, 0};
    applyStimulus(1, 1);
    for (int n = 0; n < 4000 && !(doneSeen[0] && doneSeen[1]); n++) begin
      applyStimulus(1, n == extraAt);
    end
    checkOutput("doneTimeout", int'(doneSeen[0] && doneSeen[1]), 1);
  endtask

  initial begin
    bit capSeen;
    srstz = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) checkOutput($sformatf("resetState%0d", i), packOuts(i), 0);
    srstz = 1'b1;
    repeat (2) applyStimulus(0, 0);

    $display("[TB] entry glitch");
    repeat (15) applyStimulus(1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 2; i++) checkOutput($sformatf("glitch15_%0d", i), int'(tmO[i]), 0);
    applyStimulus(0, 0);
    repeat (15) applyStimulus(1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 2; i++) checkOutput($sformatf("burst15_%0d", i), int'(tmO[i]), 0);
    applyStimulus(1, 0);
    for (int i = 0; i < 2; i++) checkOutput($sformatf("entry16_%0d", i), int'(tmO[i]), 1);

    $display("[TB] single pattern with stray start");
    runPattern($urandom_range(5, 1500));
    applyStimulus(1, 0);
    for (int i = 0; i < 2; i++) checkOutput($sformatf("patAfterFirst%0d", i), int'(patO[i]), 1);

    $display("[TB] randomized patterns");
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 4)) applyStimulus(1, 0);
      runPattern($urandom_range(5, 1600));
    end
    applyStimulus(1, 0);
    for (int i = 0; i < 2; i++) checkOutput($sformatf("patAfterRandom%0d", i), int'(patO[i]), 4);

    $display("[TB] TST drop during unload");
    applyStimulus(1, 0);
    doneSeen = '{0, 0};
    capSeen = 0;
    applyStimulus(1, 1);
    for (int n = 0; n < 3000 && !(capSeen && scanO[0] && shiftO[0] == 10'd400); n++) begin
      applyStimulus(1, 0);
      if (capO[0]) capSeen = 1;
    end
    checkOutput("unloadReach", int'(shiftO[0]), 400);
    applyStimulus(0, 0);
    for (int i = 0; i < 2; i++) checkOutput($sformatf("abortOutputs%0d", i), packOuts(i), 0);
    applyStimulus(0, 0);
    repeat (16) applyStimulus(1, 0);
    checkOutput("noDoneOnAbort", int'(doneSeen[0]), 0);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reentryMode%0d", i), int'(tmO[i]), 1);
      checkOutput($sformatf("reentryPat%0d", i), int'(patO[i]), 0);
    end

    $display("[TB] reset during capture");
    applyStimulus(1, 1);
    for (int n = 0; n < 2000 && !capO[0]; n++) applyStimulus(1, 0);
    checkOutput("captureReach", int'(capO[0]), 1);
    #2 srstz = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) checkOutput($sformatf("asyncReset%0d", i), packOuts(i), 0);
    @(negedge clk);
    repeat (2) applyStimulus(1, 0);
    srstz = 1'b1;
    repeat (20) applyStimulus(1, 0);
    for (int i = 0; i < 2; i++) checkOutput($sformatf("afterReset%0d", i), int'(tmO[i]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
